// File: rtl/bs_4_mux41.sv
// bs_4_mux41: registered 4-to-1 bus multiplexer for the bit-select/shifter datapath.
// The select code {s1,s0} picks one of A0..A3, and that word is registered onto data.
// The register updates on every rising clk edge. rst_n is a synchronous, active-low reset.
// Optional feature macro: BS_MUX_PARITY_EN adds data_par. data_par is the even parity of data,
// and it is registered on the same edge as data.
module bs_4_mux41 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] data,
`ifdef BS_MUX_PARITY_EN
    output logic             data_par,
`endif
    input  logic             s0,
    input  logic             s1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] A3
);

    logic [WIDTH-1:0] next_data_s;
    logic [WIDTH-1:0] data_r;

`ifdef BS_MUX_PARITY_EN
    logic data_par_r;

    // Even parity: 1 when the word holds an odd number of ones, so word plus parity is even.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    // Decode the select code into the word to register at the next edge.
    always_comb begin
        next_data_s = A0;
        case ({s1, s0})
            2'b00:   next_data_s = A0;
            2'b01:   next_data_s = A1;
            2'b10:   next_data_s = A2;
            2'b11:   next_data_s = A3;
            default: next_data_s = A0;
        endcase
    end

    // Output register: reset clears it; otherwise it loads the selected word every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r <= {WIDTH{1'b0}};
        end else begin
            data_r <= next_data_s;
        end
    end

`ifdef BS_MUX_PARITY_EN
    // Parity register: it is computed from the next data value, so it always matches data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_par_r <= 1'b0;
        end else begin
            data_par_r <= even_parity(next_data_s);
        end
    end

    assign data_par = data_par_r;
`endif

    assign data = data_r;

endmodule

// File: tb/tb_bs_4_mux41.sv
// tb_bs_4_mux41: directed and randomised checks of bs_4_mux41.
// The data_par checks are included only when BS_MUX_PARITY_EN is defined.
module tb_bs_4_mux41;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] data;
`ifdef BS_MUX_PARITY_EN
    logic             data_par;
`endif
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] A0;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] A2;
    logic [WIDTH-1:0] A3;

    int total;
    int passed;
    int fails;

    bs_4_mux41 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
`ifdef BS_MUX_PARITY_EN
        .data_par (data_par),
`endif
        .s0       (s0),
        .s1       (s1),
        .A0       (A0),
        .A1       (A1),
        .A2       (A2),
        .A3       (A3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [1:0] sel);
        s1 = sel[1];
        s0 = sel[0];
    endtask

    initial begin
        logic [WIDTH-1:0] exp_data;
        logic [1:0]       rsel;
        logic [WIDTH-1:0] ra0, ra1, ra2, ra3;
        logic             rrst;
        total  = 0;
        passed = 0;
        fails  = 0;

        // Test 1: hold reset for two edges with one-hot words on the inputs.
        rst_n = 1'b0;
        A0 = 4'b0001; A1 = 4'b0010; A2 = 4'b0100; A3 = 4'b1000;
        set_sel(2'b11);
        tick();
        chk("reset_edge1", data, 4'b0000);
        tick();
        chk("reset_edge2", data, 4'b0000);
`ifdef BS_MUX_PARITY_EN
        chk("reset_par", {3'b000, data_par}, 4'b0000);
`endif

        // Test 2: walk the four select codes; the first edge after reset loads its word.
        rst_n = 1'b1;
        set_sel(2'b00);
        tick();
        chk("sel00", data, 4'b0001);
        set_sel(2'b10);
        tick();
        chk("sel10", data, 4'b0100);
        set_sel(2'b01);
        tick();
        chk("sel01", data, 4'b0010);
        set_sel(2'b11);
        tick();
        chk("sel11", data, 4'b1000);

        // Test 3: a change on A3 between edges stays hidden until the next edge.
        A3 = 4'b1111;
        #1;
        A3 = 4'b0110;
        #2;
        chk("hold_between_edges", data, 4'b1000);
        tick();
        chk("a3_update", data, 4'b0110);

        // Test 4: reset in mid-stream clears data, and data recovers one edge after release.
        A3 = 4'b1000;
        set_sel(2'b01);
        tick();
        chk("steady_sel01", data, 4'b0010);
        rst_n = 1'b0;
        tick();
        chk("midstream_reset", data, 4'b0000);
`ifdef BS_MUX_PARITY_EN
        chk("midstream_reset_par", {3'b000, data_par}, 4'b0000);
`endif
        rst_n = 1'b1;
        tick();
        chk("reset_release", data, 4'b0010);

        // Test 5: words with odd and even numbers of ones (parity 1 and 0).
        A2 = 4'b0111;
        set_sel(2'b10);
        tick();
        chk("odd_word", data, 4'b0111);
`ifdef BS_MUX_PARITY_EN
        chk("par_odd", {3'b000, data_par}, 4'b0001);
`endif
        A2 = 4'b0011;
        tick();
        chk("even_word", data, 4'b0011);
`ifdef BS_MUX_PARITY_EN
        chk("par_even", {3'b000, data_par}, 4'b0000);
`endif

        // Test 6: random select, inputs and occasional resets against a one-cycle-delayed model.
        for (int i = 0; i < 300; i++) begin
            rsel = 2'($urandom_range(0, 3));
            ra0  = 4'($urandom);
            ra1  = 4'($urandom);
            ra2  = 4'($urandom);
            ra3  = 4'($urandom);
            rrst = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
            A0 = ra0; A1 = ra1; A2 = ra2; A3 = ra3;
            set_sel(rsel);
            rst_n = rrst;
            if (!rrst)               exp_data = 4'b0000;
            else if (rsel == 2'b00)  exp_data = ra0;
            else if (rsel == 2'b01)  exp_data = ra1;
            else if (rsel == 2'b10)  exp_data = ra2;
            else                     exp_data = ra3;
            tick();
            chk("random_data", data, exp_data);
`ifdef BS_MUX_PARITY_EN
            chk("random_par", {3'b000, data_par}, {3'b000, ^exp_data});
`endif
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
